pe_mem_arbiter: RTL
===================

# pe_mem_arbiter

Round-robin arbiter that shares one memory port among `N_PE` processing elements in the CGRA array. Each PE raises `mem_read` or `mem_write` with an address, and the arbiter grants one PE at a time. It drives the single-outstanding memory handshake, then returns `mem_ack` (writes) or `data_Ready` plus read data (reads) to the granted PE. A watchdog aborts hung transactions so a PE controller never stalls forever.

## Interface
Parameters:
- `N_PE`, 4, number of requesting PEs (2..16)
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 64, maximum cycles in BUSY before abort (≥2)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `pe_read`  in  N_PE  per-PE read request, level
- `pe_write`  in  N_PE  per-PE write request, level
- `pe_addr`  in  N_PE*AW  packed addresses, PE i at [i*AW +: AW]
- `pe_wdata`  in  N_PE*DW  packed write data
- `pe_ack`  out  N_PE  one-cycle write-complete pulse, to PE `mem_ack`
- `pe_ready`  out  N_PE  one-cycle read-data-valid pulse, to PE `data_Ready`
- `pe_rdata`  out  DW  read data, shared bus, valid with `pe_ready`
- `mem_req`  out  1  memory request, held until `mem_done`
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  AW  latched address
- `mem_wdata`  out  DW  latched write data
- `mem_done`  in  1  memory completion pulse; `mem_rdata` valid same cycle
- `mem_rdata`  in  DW  read data
- `grant_id`  out  $clog2(N_PE)  index of current/last grant (debug)
- `timeout_err`  out  1  one-cycle pulse on watchdog abort

## Operation
- FSM states:
  - IDLE: when any PE has `pe_read|pe_write`, pick the winner round-robin, searching from `last+1` mod N_PE. Latch index, addr, wdata and we (`we` = `pe_write[i]`), then go to BUSY.
  - BUSY: `mem_req`=1 with stable latched fields.
    - On `mem_done`: latch `mem_rdata` into `pe_rdata` (reads only), go to RESP.
    - When the watchdog reaches `TIMEOUT-1` without `mem_done`: set `pe_rdata`=0, pulse `timeout_err`, go to RESP.
  - RESP: pulse `pe_ack[g]` (write) or `pe_ready[g]` (read) for exactly one cycle; `mem_req`=0; update `last`=g; go to RELEASE.
  - RELEASE: one dead cycle so the PE can drop its request; requests from g are ignored this cycle. Go to IDLE.
- Same PE asserting read and write together: served as a write; the read is dropped.
- Requests that drop before they are granted are simply not served. Request changes after the grant are ignored, because fields are latched.
- `mem_done` outside BUSY is ignored. `mem_done` on the same cycle the watchdog expires counts as success: no `timeout_err`, real data returned.
- Watchdog counter clears on entry to BUSY and is $clog2(TIMEOUT)+1 bits wide.
- Reset, including mid-transaction:
  - State goes to IDLE.
  - `mem_req`, `mem_we`, `pe_ack`, `pe_ready`, `timeout_err` = 0.
  - `mem_addr`, `mem_wdata`, `pe_rdata` = 0.
  - `last` = N_PE-1, so PE0 wins first; `grant_id` = 0.
  - The in-flight transaction is abandoned without any response pulse.

## Timing
- All outputs are registered.
- Minimum latency, request seen in IDLE at cycle 0:
  - `mem_req` high from cycle 1.
  - `mem_done` at cycle 1 gives the response pulse at cycle 2.
  - Arbiter back in IDLE at cycle 4.
- Throughput with zero-wait memory: one transaction per 4 cycles.
- Fairness: a continuously requesting PE waits at most N_PE-1 other transactions.
- A timeout produces its response pulse at cycle TIMEOUT+1 after the grant.

## Structure
- Shared package `cgra_bus_pkg`: FSM state enum (IDLE, BUSY, RESP, RELEASE) and default AW/DW constants.
- One sub-module, `rr_pick`: combinational round-robin priority encoder. Inputs are the request vector and `last`; outputs are a valid flag and the winner index. The rest stays in the top module.

## Test plan
- Single read: PE2 reads 0x100; memory returns 0xDEADBEEF after 3 wait cycles -> `mem_req` high for 4 cycles, `mem_we`=0, `mem_addr`=0x100; one-cycle `pe_ready[2]` with `pe_rdata`=0xDEADBEEF; no `pe_ack`.
- Round-robin: PEs 0-3 all hold write requests, zero-wait memory -> grants in order 0,1,2,3,0, spaced 4 cycles apart; each `pe_ack[i]` pulses once per grant.
- Timeout: PE1 writes, `mem_done` never asserted, TIMEOUT=8 -> `mem_req` drops after 8 BUSY cycles; `timeout_err` and `pe_ack[1]` pulse; FSM returns to IDLE.
- Read+write conflict: PE3 asserts both with wdata 0x55 -> `mem_we`=1, `mem_wdata`=0x55; only `pe_ack[3]` pulses.
- Reset mid-BUSY: assert `reset` while serving PE1 -> next cycle `mem_req`=0 and all pulses 0; no response to PE1; the next request from PE0 and PE1 together grants PE0.
- Late `mem_done`: inject `mem_done` in IDLE and RELEASE -> no outputs change.

Source files
------------

// File: rtl/cgra_bus_pkg.sv
// rtl/cgra_bus_pkg.sv - shared types and constants for the CGRA memory bus
package cgra_bus_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int DEFAULT_AW = 32;
    localparam int DEFAULT_DW = 32;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder
//
// Purpose: choose the first requester after `last`, wrapping modulo N_PE.
// Ports:
//   req    - request vector, one bit per PE
//   last   - index of the most recently served PE (lowest priority)
//   valid  - at least one request is present
//   winner - index of the selected PE (0 when valid is low)
module rr_pick
    import cgra_bus_pkg::*;
#(
    parameter  int N_PE = 4,
    localparam int IW   = $clog2(N_PE)
) (
    input  logic [N_PE-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   winner
);

    logic [2*N_PE-1:0] req_dbl;
    logic [N_PE-1:0]   req_rot;
    int                sum;

    // Rotate so bit j of req_rot is PE (last+1+j) mod N_PE; the lowest set
    // bit is then the round-robin winner.
    assign req_dbl = {req, req};
    assign req_rot = N_PE'(req_dbl >> (int'(last) + 1));

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        sum    = 0;
        for (int j = N_PE - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                valid = 1'b1;
                sum   = int'(last) + 1 + j;
                if (sum >= N_PE) begin
                    sum = sum - N_PE;
                end
                winner = IW'(sum);
            end
        end
    end

endmodule

// File: rtl/pe_mem_arbiter.sv
// rtl/pe_mem_arbiter.sv - round-robin arbiter sharing one memory port among PEs
//
// Purpose: grant one PE at a time, run a single-outstanding memory handshake,
// and return a one-cycle ack (write) or ready+data (read) to the granted PE.
// A watchdog aborts a transaction the memory never completes.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   pe_read, pe_write     - per-PE level requests
//   pe_addr, pe_wdata     - packed per-PE address / write data
//   pe_ack, pe_ready      - per-PE one-cycle completion pulses
//   pe_rdata              - shared read data, valid with pe_ready
//   mem_req/we/addr/wdata - memory request side, held until mem_done
//   mem_done, mem_rdata   - memory completion pulse and read data
//   grant_id              - index of current/last grant
//   timeout_err           - one-cycle pulse on watchdog abort
module pe_mem_arbiter
    import cgra_bus_pkg::*;
#(
    parameter  int N_PE    = 4,
    parameter  int AW      = DEFAULT_AW,
    parameter  int DW      = DEFAULT_DW,
    parameter  int TIMEOUT = 64,
    localparam int IW      = $clog2(N_PE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_PE-1:0]   pe_read,
    input  logic [N_PE-1:0]   pe_write,
    input  logic [N_PE*AW-1:0] pe_addr,
    input  logic [N_PE*DW-1:0] pe_wdata,
    output logic [N_PE-1:0]   pe_ack,
    output logic [N_PE-1:0]   pe_ready,
    output logic [DW-1:0]     pe_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_done,
    input  logic [DW-1:0]     mem_rdata,
    output logic [IW-1:0]     grant_id,
    output logic              timeout_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    arb_state_t      state_q,   state_d;
    logic [IW-1:0]   gnt_q,     gnt_d;
    logic [IW-1:0]   last_q,    last_d;
    logic [AW-1:0]   addr_q,    addr_d;
    logic [DW-1:0]   wdata_q,   wdata_d;
    logic            we_q,      we_d;
    logic            req_q,     req_d;
    logic [N_PE-1:0] ack_q,     ack_d;
    logic [N_PE-1:0] ready_q,   ready_d;
    logic [DW-1:0]   rdata_q,   rdata_d;
    logic            terr_q,    terr_d;
    logic [CW-1:0]   wdog_q,    wdog_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_we;

    // A PE asserting both read and write is served as a write.
    rr_pick #(.N_PE(N_PE)) u_rr_pick (
        .req    (pe_read | pe_write),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < N_PE; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_addr  = pe_addr[i*AW +: AW];
                sel_wdata = pe_wdata[i*DW +: DW];
                sel_we    = pe_write[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        wdog_d  = wdog_q;
        ack_d   = '0;
        ready_d = '0;
        terr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    req_d   = 1'b1;
                    wdog_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // mem_done wins over a watchdog expiring in the same cycle.
                if (mem_done) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    req_d          = 1'b0;
                    ack_d[gnt_q]   = we_q;
                    ready_d[gnt_q] = !we_q;
                    state_d        = RESP;
                end else if (wdog_q == CW'(TIMEOUT - 1)) begin
                    rdata_d        = '0;
                    terr_d         = 1'b1;
                    req_d          = 1'b0;
                    ack_d[gnt_q]   = we_q;
                    ready_d[gnt_q] = !we_q;
                    state_d        = RESP;
                end else begin
                    wdog_d = wdog_q + CW'(1);
                end
            end
            RESP: begin
                last_d  = gnt_q;
                state_d = RELEASE;
            end
            RELEASE: begin
                // Dead cycle: the served PE gets time to drop its request.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(N_PE - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            ack_q   <= '0;
            ready_q <= '0;
            rdata_q <= '0;
            terr_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            terr_q  <= terr_d;
            wdog_q  <= wdog_d;
        end
    end

    assign pe_ack      = ack_q;
    assign pe_ready    = ready_q;
    assign pe_rdata    = rdata_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign grant_id    = gnt_q;
    assign timeout_err = terr_q;

endmodule
